thread_sched: RTL and testbench
===============================

// Module: thread_sched
// PURPOSE
//  Round-robin fetch scheduler for the 8-way barrel-threaded PC stage. Tracks a per-thread state
//  (IDLE/RUN/BR_WAIT/HALT), picks the next thread id for the PC each cycle, skipping blocked threads.
//  Accepts branch resolutions and returns taken targets to the PC through a valid/ack redirect port.
// PARAMETERS
//  NTHREADS  8        number of hardware threads (power of two)
//  TID_W     3        thread id width, $clog2(NTHREADS)
//  XLEN      `XLEN    address width of redirect target
// PORTS
//  clk          in   1            clock
//  rst          in   1            reset, asynchronous, active-low
//  stall_i      in   1            freeze selection outputs and round-robin pointer
//  thr_en_i     in   NTHREADS     per-thread enable mask (software controlled)
//  dec_br_i     in   1            decode saw branch/jump for thread dec_tid_i
//  dec_tid_i    in   TID_W        thread of dec_br_i
//  halt_i       in   1            thread halt_tid_i executed halt/ecall
//  halt_tid_i   in   TID_W        thread of halt_i
//  res_valid_i  in   1            branch resolution offered
//  res_ready_o  out  1            resolution accepted this cycle when valid&ready
//  res_tid_i    in   TID_W        thread of resolution
//  res_taken_i  in   1            branch taken
//  res_pc_i     in   XLEN         taken target
//  sel_valid_o  out  1            sel_tid_o is a fetch slot
//  sel_tid_o    out  TID_W        thread the PC issues next
//  redir_valid_o out 1            redirect pending to PC
//  redir_tid_o  out  TID_W        redirect thread
//  redir_pc_o   out  XLEN         redirect target
//  redir_ack_i  in   1            PC consumed redirect
//  proto_err_o  out  1            one-cycle pulse: resolution for thread not in BR_WAIT
//  idle_o       out  1            no thread in RUN
// BEHAVIOUR
//  - Reset: all threads IDLE, rr pointer 0, sel_valid_o 0, sel_tid_o 0, redir_valid_o 0, redir_tid_o 0,
//    redir_pc_o 0, proto_err_o 0, idle_o 1. Reset may assert mid-operation; in-flight redirect is dropped.
//  - State encoding 2'b00 IDLE, 01 RUN, 10 BR_WAIT, 11 HALT. Transitions per thread, evaluated each edge:
//    IDLE->RUN when thr_en bit 1; RUN->IDLE when en 0; RUN->BR_WAIT on dec_br_i; any non-IDLE->HALT on halt_i;
//    HALT->IDLE only when en 0; BR_WAIT->RUN on accepted not-taken resolution or on redir_ack_i for its redirect.
//  - en dropped while BR_WAIT: stays BR_WAIT until resolved, then IDLE instead of RUN.
//  - Priority, same thread same cycle: halt_i > resolution > dec_br_i > enable change.
//  - Selection: eligible = (state==RUN). Rotating priority starting at last granted tid+1, wrap NTHREADS-1->0.
//    Outputs registered: events at edge t affect the selection visible after edge t+1 (1-cycle latency).
//    No eligible thread: sel_valid_o 0, pointer unchanged, sel_tid_o holds.
//  - stall_i=1: sel_valid_o, sel_tid_o, pointer hold; state updates and redirect handshake still proceed.
//  - Resolution handshake: res_ready_o = !redir_valid_o | redir_ack_i (combinational).
//    Accepted taken: redir_* loaded next edge, held stable until redir_ack_i; thread stays BR_WAIT meanwhile.
//    Accepted for thread not in BR_WAIT: state unchanged, no redirect, proto_err_o pulses next cycle.
//  - redir_pc_o passes res_pc_i unmodified; low 2 bits not checked.
//  - idle_o = no thread in RUN (registered with state).
// STRUCTURE
//  - constants.vh: NTHREADS, TID_W defaults; struct.v: thr_state_t enum, sched_redir struct (valid,tid,pc)
//    consumed by the PC stage.
//  - One sub-module: rr_arbiter #(N) (req[N], base ptr -> grant one-hot, grant index, any), combinational.
//  - Top holds per-thread state regs, pointer, redirect register.
// TESTING
//  1 Reset, thr_en=8'h05 -> cycle 2+ sel_tid alternates 0,2,0,2; sel_valid 1; idle_o 0.
//  2 thr_en=FF, dec_br tid 3 -> tid 3 absent from selection until resolved; resolve not-taken -> 3 returns
//    within 8 cycles, no redirect.
//  3 Taken res tid 5 pc 32'h100 with redir_ack low 4 cycles -> redir held 4 cycles, res_ready 0,
//    second res stalls; ack -> tid 5 RUN, second res accepted same cycle.
//  4 halt tid 1 and dec_br tid 1 same cycle -> HALT; thr_en[1]=0 -> IDLE; =1 -> RUN.
//  5 Resolution for RUN tid 6 -> proto_err_o one pulse, no redir, tid 6 selection unchanged.
//  6 stall_i 3 cycles mid-rotation -> sel_tid frozen, resumes at next tid; async rst mid-redirect ->
//    all outputs reset values immediately.

Source files
------------

// File: rtl/thread_sched_pkg.sv
// thread_sched_pkg: shared constants and types for the barrel-thread fetch scheduler
package thread_sched_pkg;
  localparam int NTHREADS = 8;
  localparam int TID_W = $clog2(NTHREADS);
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, BR_WAIT = 2'b10, HALT = 2'b11} thr_state_t;
  typedef struct packed {
    logic valid;
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0] pc;
  } sched_redir_t;
endpackage

// File: rtl/thread_sched_if.sv
// thread_sched_if: branch-resolution offer and PC redirect handshake
interface thread_sched_if;
  import thread_sched_pkg::*;
  logic res_valid, res_ready, res_taken, redir_valid, redir_ack;
  logic [TID_W-1:0] res_tid, redir_tid;
  logic [XLEN-1:0] res_pc, redir_pc;
  modport master(output res_valid, res_tid, res_taken, res_pc, redir_ack,
                 input res_ready, redir_valid, redir_tid, redir_pc);
  modport slave(input res_valid, res_tid, res_taken, res_pc, redir_ack,
                output res_ready, redir_valid, redir_tid, redir_pc);
endinterface

// File: rtl/thread_sched_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick, first request at or after base
module rr_arbiter #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = base;
    for (int k = 0; k < N; k++) begin
      j = base + W'(k);
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/thread_sched.sv
// thread_sched: per-thread state tracking, round-robin fetch select and branch redirect
module thread_sched
  import thread_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [NTHREADS-1:0] thr_en,
  input  logic                dec_br,
  input  logic [TID_W-1:0]    dec_tid,
  input  logic                halt,
  input  logic [TID_W-1:0]    halt_tid,
  thread_sched_if.slave       bus,
  output logic                sel_valid,
  output logic [TID_W-1:0]    sel_tid,
  output logic                proto_err,
  output logic                idle
);
  thr_state_t st [NTHREADS];
  thr_state_t st_nx [NTHREADS];
  sched_redir_t redir, redir_nx;
  logic [TID_W-1:0] ptr, gnt_idx;
  logic [NTHREADS-1:0] run, gnt;
  logic any, acc, acc_bw, idle_nx;
  assign bus.res_ready = !redir.valid | bus.redir_ack;
  assign acc = bus.res_valid & bus.res_ready;
  assign acc_bw = acc & (st[bus.res_tid] == BR_WAIT);
  assign bus.redir_valid = redir.valid;
  assign bus.redir_tid = redir.tid;
  assign bus.redir_pc = redir.pc;
  always_comb begin
    idle_nx = 1'b1;
    for (int i = 0; i < NTHREADS; i++) begin
      run[i] = st[i] == RUN;
      st_nx[i] = st[i];
      if (halt && halt_tid == TID_W'(i) && st[i] != IDLE) st_nx[i] = HALT;
      else if (acc && bus.res_tid == TID_W'(i)) begin
        if (st[i] == BR_WAIT && !bus.res_taken) st_nx[i] = thr_en[i] ? RUN : IDLE;
      end
      else if (bus.redir_ack && redir.valid && redir.tid == TID_W'(i) && st[i] == BR_WAIT)
        st_nx[i] = thr_en[i] ? RUN : IDLE;
      else if (dec_br && dec_tid == TID_W'(i) && st[i] == RUN) st_nx[i] = BR_WAIT;
      else if (st[i] == IDLE && thr_en[i]) st_nx[i] = RUN;
      else if ((st[i] == RUN || st[i] == HALT) && !thr_en[i]) st_nx[i] = IDLE;
      idle_nx &= st_nx[i] != RUN;
    end
  end
  // a taken resolution reloads the slot in the same cycle an ack frees it
  always_comb begin
    redir_nx = redir;
    if (bus.redir_ack) redir_nx.valid = 1'b0;
    if (acc_bw && bus.res_taken) redir_nx = {1'b1, bus.res_tid, bus.res_pc};
  end
  rr_arbiter #(.N(NTHREADS)) u_arb (.req(run), .base(ptr), .grant(gnt), .idx(gnt_idx), .any(any));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '{default: IDLE};
      redir <= '0;
      ptr <= '0;
      sel_valid <= 1'b0;
      sel_tid <= '0;
      proto_err <= 1'b0;
      idle <= 1'b1;
    end else begin
      st <= st_nx;
      redir <= redir_nx;
      proto_err <= acc & !acc_bw;
      idle <= idle_nx;
      if (!stall) begin
        sel_valid <= |gnt;
        if (any) begin
          sel_tid <= gnt_idx;
          ptr <= gnt_idx + TID_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: scoreboard bench for thread_sched against a rule-level reference model
module tb_thread_sched;
  import thread_sched_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, dec_br = 1'b0, halt = 1'b0;
  logic [NTHREADS-1:0] thr_en = '0;
  logic [TID_W-1:0] dec_tid = '0, halt_tid = '0;
  logic sel_valid, proto_err, idle;
  logic [TID_W-1:0] sel_tid;
  thread_sched_if bus();
  thread_sched dut (.clk(clk), .rst_n(rst_n), .stall(stall), .thr_en(thr_en), .dec_br(dec_br),
                    .dec_tid(dec_tid), .halt(halt), .halt_tid(halt_tid), .bus(bus),
                    .sel_valid(sel_valid), .sel_tid(sel_tid), .proto_err(proto_err), .idle(idle));
  always #5 clk = ~clk;

  typedef struct packed {
    logic sv;
    logic [TID_W-1:0] tid;
    logic idl;
    logic pe;
    logic rv;
    logic [TID_W-1:0] rt;
    logic [XLEN-1:0] rp;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int passed = 0, total = 0;

  thr_state_t m_st [NTHREADS];
  int m_ptr, m_tid, m_rt;
  bit m_sv, m_idle, m_pe, m_rv;
  logic [XLEN-1:0] m_rp;

  function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, expected %0h", n, got, want);
  endfunction

  function automatic void m_reset();
    foreach (m_st[i]) m_st[i] = IDLE;
    m_ptr = 0; m_tid = 0; m_rt = 0; m_rp = '0;
    m_sv = 0; m_idle = 1; m_pe = 0; m_rv = 0;
  endfunction

  // Lower-priority events are applied first and overwritten by higher-priority ones.
  function automatic void model();
    thr_state_t nx [NTHREADS];
    bit acc;
    int r;
    nx = m_st;
    acc = bus.res_valid && (!m_rv || bus.redir_ack);
    r = int'(bus.res_tid);
    for (int i = 0; i < NTHREADS; i++) begin
      if (thr_en[i] && m_st[i] == IDLE) nx[i] = RUN;
      if (!thr_en[i] && (m_st[i] == RUN || m_st[i] == HALT)) nx[i] = IDLE;
    end
    if (dec_br && m_st[dec_tid] == RUN) nx[dec_tid] = BR_WAIT;
    if (bus.redir_ack && m_rv && m_st[m_rt] == BR_WAIT) nx[m_rt] = thr_en[m_rt] ? RUN : IDLE;
    if (acc) nx[r] = (m_st[r] == BR_WAIT && !bus.res_taken) ? (thr_en[r] ? RUN : IDLE) : m_st[r];
    if (halt && m_st[halt_tid] != IDLE) nx[halt_tid] = HALT;
    m_pe = acc && m_st[r] != BR_WAIT;
    if (acc && m_st[r] == BR_WAIT && bus.res_taken) begin
      m_rv = 1; m_rt = r; m_rp = bus.res_pc;
    end else if (bus.redir_ack) m_rv = 0;
    if (!stall) begin
      m_sv = 0;
      for (int k = NTHREADS - 1; k >= 0; k--)
        if (m_st[(m_ptr + k) % NTHREADS] == RUN) begin
          m_sv = 1; m_tid = (m_ptr + k) % NTHREADS;
        end
      if (m_sv) m_ptr = (m_tid + 1) % NTHREADS;
    end
    m_idle = 1;
    foreach (nx[i]) if (nx[i] == RUN) m_idle = 0;
    m_st = nx;
    q.push_back({m_sv, TID_W'(m_tid), m_idle, m_pe, m_rv, TID_W'(m_rt), m_rp});
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("sel_valid", 64'(sel_valid), 64'(me.sv));
      chk("sel_tid", 64'(sel_tid), 64'(me.tid));
      chk("idle", 64'(idle), 64'(me.idl));
      chk("proto_err", 64'(proto_err), 64'(me.pe));
      chk("redir_valid", 64'(bus.redir_valid), 64'(me.rv));
      chk("redir_tid", 64'(bus.redir_tid), 64'(me.rt));
      chk("redir_pc", 64'(bus.redir_pc), 64'(me.rp));
    end
  end

  task automatic step();
    #1 chk("res_ready", 64'(bus.res_ready), 64'(!m_rv || bus.redir_ack));
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_sel_valid"}, 64'(sel_valid), 0);
    chk({n, "_sel_tid"}, 64'(sel_tid), 0);
    chk({n, "_redir_valid"}, 64'(bus.redir_valid), 0);
    chk({n, "_redir_tid"}, 64'(bus.redir_tid), 0);
    chk({n, "_redir_pc"}, 64'(bus.redir_pc), 0);
    chk({n, "_proto_err"}, 64'(proto_err), 0);
    chk({n, "_idle"}, 64'(idle), 1);
  endtask

  initial begin
    bit seen;
    int bw[$];
    int tids[4];
    bus.res_valid = 0; bus.res_tid = '0; bus.res_taken = 0; bus.res_pc = '0; bus.redir_ack = 0;
    m_reset();
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    // two enabled threads alternate once the first selection registers
    thr_en = 8'h05;
    step(); step();
    chk("t1_valid", 64'(sel_valid), 1);
    chk("t1_idle", 64'(idle), 0);
    tids = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      chk("t1_seq", 64'(sel_tid), 64'(tids[i]));
      step();
    end
    // branch wait removes a thread until its not-taken resolution
    thr_en = 8'hFF;
    repeat (2) step();
    dec_br = 1; dec_tid = 3;
    step();
    dec_br = 0;
    repeat (8) begin
      step();
      chk("t2_absent", 64'(sel_valid && sel_tid == 3), 0);
    end
    bus.res_valid = 1; bus.res_tid = 3; bus.res_taken = 0;
    step();
    bus.res_valid = 0;
    seen = 0;
    repeat (9) begin
      step();
      if (sel_valid && sel_tid == 3) seen = 1;
    end
    chk("t2_back", 64'(seen), 1);
    chk("t2_noredir", 64'(bus.redir_valid), 0);
    // taken redirect held while unacked; a second resolution waits for the ack
    dec_br = 1; dec_tid = 5; step();
    dec_tid = 2; step();
    dec_br = 0;
    bus.res_valid = 1; bus.res_tid = 5; bus.res_taken = 1; bus.res_pc = 32'h100;
    step();
    bus.res_tid = 2; bus.res_taken = 0; bus.res_pc = 32'h0;
    repeat (4) begin
      chk("t3_rv", 64'(bus.redir_valid), 1);
      chk("t3_rt", 64'(bus.redir_tid), 5);
      chk("t3_rp", 64'(bus.redir_pc), 64'h100);
      #1 chk("t3_ready_low", 64'(bus.res_ready), 0);
      step();
    end
    bus.redir_ack = 1;
    #1 chk("t3_ready_ack", 64'(bus.res_ready), 1);
    step();
    bus.redir_ack = 0; bus.res_valid = 0;
    chk("t3_cleared", 64'(bus.redir_valid), 0);
    repeat (3) step();
    // halt beats a same-cycle branch; only disable clears HALT
    halt = 1; halt_tid = 1; dec_br = 1; dec_tid = 1;
    step();
    halt = 0; dec_br = 0;
    repeat (4) begin
      step();
      chk("t4_halted", 64'(sel_valid && sel_tid == 1), 0);
    end
    thr_en[1] = 0; repeat (2) step();
    thr_en[1] = 1; repeat (10) step();
    // resolution for a running thread is a protocol error only
    bus.res_valid = 1; bus.res_tid = 6; bus.res_taken = 1; bus.res_pc = 32'h200;
    step();
    bus.res_valid = 0;
    chk("t5_pulse", 64'(proto_err), 1);
    chk("t5_noredir", 64'(bus.redir_valid), 0);
    step();
    chk("t5_end", 64'(proto_err), 0);
    // stall freezes selection
    repeat (2) step();
    stall = 1; repeat (3) step();
    stall = 0; repeat (3) step();
    // async reset with a redirect in flight
    dec_br = 1; dec_tid = 4; step();
    dec_br = 0;
    bus.res_valid = 1; bus.res_tid = 4; bus.res_taken = 1; bus.res_pc = 32'hDEAD_BEE0;
    step();
    bus.res_valid = 0;
    step();
    chk("t6_pending", 64'(bus.redir_valid), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset("arst");
    q.delete();
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    thr_en = 8'hFF;
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(15) == 0) thr_en[$urandom_range(NTHREADS - 1)] ^= 1'b1;
      stall = $urandom_range(7) == 0;
      dec_br = $urandom_range(2) == 0;
      dec_tid = TID_W'($urandom_range(NTHREADS - 1));
      halt = $urandom_range(31) == 0;
      halt_tid = TID_W'($urandom_range(NTHREADS - 1));
      bw.delete();
      foreach (m_st[i]) if (m_st[i] == BR_WAIT) bw.push_back(i);
      bus.res_valid = $urandom_range(1) == 1;
      if (bw.size() > 0 && $urandom_range(7) != 0)
        bus.res_tid = TID_W'(bw[$urandom_range(bw.size() - 1)]);
      else bus.res_tid = TID_W'($urandom_range(NTHREADS - 1));
      bus.res_taken = $urandom_range(1) == 1;
      bus.res_pc = XLEN'($urandom);
      bus.redir_ack = $urandom_range(1) == 1;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
